// File: rtl/alu_exec_stage.sv
// Execute stage: wraps the combinational alu, queues results in a 2-entry skid FIFO,
// and holds the flags register plus the branch-condition evaluator.

module alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] out,
  output logic [7:0]        flags
);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_PSB = 3'd7;

  logic [DATA_W:0] wide;
  logic            carry;
  logic            ovf;
  logic            zero;
  logic            neg;
  logic            par;

  // Carry is a borrow on SUB; shifts report the bit shifted out.
  always_comb begin
    wide  = '0;
    out   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        out   = wide[DATA_W-1:0];
        carry = wide[DATA_W];
        ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (out[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        out   = wide[DATA_W-1:0];
        carry = wide[DATA_W];
        ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (out[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND: out = a & b;
      OP_OR:  out = a | b;
      OP_XOR: out = a ^ b;
      OP_SHL: begin
        out   = {a[DATA_W-2:0], 1'b0};
        carry = a[DATA_W-1];
      end
      OP_SHR: begin
        out   = {1'b0, a[DATA_W-1:1]};
        carry = a[0];
      end
      OP_PSB: out = b;
      default: out = '0;
    endcase
  end

  // Parity flag is set when the result has an even number of ones.
  assign zero  = (out == '0);
  assign neg   = out[DATA_W-1];
  assign par   = ~^out;
  assign flags = {3'b000, par, ovf, carry, neg, zero};
endmodule

module alu_exec_stage #(
  parameter int DATA_W  = 8,
  parameter int RD_W    = 3,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]  in_b,
  input  logic [2:0]         in_op,
  input  logic [RD_W-1:0]    in_rd,
  input  logic               in_setflags,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [RD_W-1:0]    out_rd,
  output logic [7:0]         flags_q,
  input  logic [2:0]         cond,
  output logic               cond_true,
  output logic [STALL_W-1:0] stall_cnt
);
  localparam logic [2:0] CC_AL  = 3'd0;
  localparam logic [2:0] CC_EQ  = 3'd1;
  localparam logic [2:0] CC_NE  = 3'd2;
  localparam logic [2:0] CC_LT  = 3'd3;
  localparam logic [2:0] CC_GE  = 3'd4;
  localparam logic [2:0] CC_CS  = 3'd5;
  localparam logic [2:0] CC_CC  = 3'd6;
  localparam logic [2:0] CC_PAR = 3'd7;

  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
  localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] alu_out;
  logic [7:0]        alu_flags;

  logic [DATA_W-1:0] mem_result [2];
  logic [RD_W-1:0]   mem_rd     [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  alu #(.DATA_W(DATA_W)) u_alu (
    .a     (in_a),
    .b     (in_b),
    .op    (in_op),
    .out   (alu_out),
    .flags (alu_flags)
  );

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready   = !rst && (count != 2'd2);
  assign out_valid  = (count != 2'd0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_result = mem_result[rd_ptr];
  assign out_rd     = mem_rd[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_result[0] <= '0;
      mem_result[1] <= '0;
      mem_rd[0]     <= '0;
      mem_rd[1]     <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= 2'd0;
    end else begin
      if (push) begin
        mem_result[wr_ptr] <= alu_out;
        mem_rd[wr_ptr]     <= in_rd;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 8'h00;
    end else if (push && in_setflags) begin
      flags_q <= alu_flags;
    end
  end

  // Saturates rather than wrapping so long stalls stay visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + STALL_ONE;
    end
  end

  always_comb begin
    cond_true = 1'b1;
    case (cond)
      CC_AL:   cond_true = 1'b1;
      CC_EQ:   cond_true = flags_q[0];
      CC_NE:   cond_true = !flags_q[0];
      CC_LT:   cond_true = flags_q[1] ^ flags_q[3];
      CC_GE:   cond_true = !(flags_q[1] ^ flags_q[3]);
      CC_CS:   cond_true = flags_q[2];
      CC_CC:   cond_true = !flags_q[2];
      CC_PAR:  cond_true = flags_q[4];
      default: cond_true = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage; a second instance with a 4-bit stall counter
// shares the inputs and is only checked for saturation.

module tb_alu_exec_stage;
  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic [2:0] in_rd;
  logic       in_setflags;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [2:0] out_rd;
  logic [7:0] flags_q;
  logic [2:0] cond;
  logic       cond_true;
  logic [15:0] stall_cnt;

  logic       sat_in_ready;
  logic       sat_out_valid;
  logic [7:0] sat_out_result;
  logic [2:0] sat_out_rd;
  logic [7:0] sat_flags_q;
  logic       sat_cond_true;
  logic [3:0] sat_stall_cnt;

  int vector_count = 0;
  int miss_count   = 0;

  alu_exec_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_rd(in_rd),
    .in_setflags(in_setflags), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .flags_q(flags_q),
    .cond(cond), .cond_true(cond_true), .stall_cnt(stall_cnt)
  );

  alu_exec_stage #(.STALL_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_rd(in_rd),
    .in_setflags(in_setflags), .out_valid(sat_out_valid), .out_ready(out_ready),
    .out_result(sat_out_result), .out_rd(sat_out_rd), .flags_q(sat_flags_q),
    .cond(cond), .cond_true(sat_cond_true), .stall_cnt(sat_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] op, input logic [2:0] rd, input logic setflags);
    in_valid    = valid;
    in_a        = a;
    in_b        = b;
    in_op       = op;
    in_rd       = rd;
    in_setflags = setflags;
  endtask

  task automatic checkCond(input logic [2:0] sel, input logic expected, input string tag);
    cond = sel;
    #1;
    checkOutput(tag, cond_true, expected);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    cond = 3'd0;
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
    tick();
    tick();
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_result", out_result, 0);
    checkOutput("reset_rd", out_rd, 0);
    checkOutput("reset_flags", flags_q, 0);
    checkOutput("reset_stall", stall_cnt, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", in_ready, 1);

    // ADD 7F+01 with flags: result 80, N=1 V=1, odd parity
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'h7F, 8'h01, 3'd0, 3'd3, 1'b1);
    #1;
    checkOutput("flags_before_edge", flags_q, 8'h00);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
    checkOutput("add_valid", out_valid, 1);
    checkOutput("add_result", out_result, 8'h80);
    checkOutput("add_rd", out_rd, 3);
    checkOutput("add_flags", flags_q, 8'h0A);
    checkCond(3'd3, 1'b0, "cond_lt");
    checkCond(3'd4, 1'b1, "cond_ge");
    checkCond(3'd0, 1'b1, "cond_al");
    checkCond(3'd1, 1'b0, "cond_eq_clear");
    tick();
    checkOutput("add_drained", out_valid, 0);

    // SUB 05-05 without flag update keeps old flags
    applyStimulus(1'b1, 8'h05, 8'h05, 3'd1, 3'd5, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
    checkOutput("sub_result", out_result, 8'h00);
    checkOutput("sub_rd", out_rd, 5);
    checkOutput("sub_noflags", flags_q, 8'h0A);
    checkCond(3'd1, 1'b0, "cond_eq_old");
    tick();

    applyStimulus(1'b1, 8'h05, 8'h05, 3'd1, 3'd6, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
    checkOutput("sub_flags", flags_q, 8'h11);
    checkCond(3'd1, 1'b1, "cond_eq_set");
    checkCond(3'd7, 1'b1, "cond_par");
    checkCond(3'd6, 1'b1, "cond_cc");
    tick();

    applyStimulus(1'b1, 8'hFF, 8'h01, 3'd0, 3'd7, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
    checkOutput("carry_result", out_result, 8'h00);
    checkOutput("carry_flags", flags_q, 8'h15);
    checkCond(3'd5, 1'b1, "cond_cs");
    checkCond(3'd2, 1'b0, "cond_ne");
    tick();

    applyStimulus(1'b1, 8'h03, 8'h09, 3'd1, 3'd2, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
    checkOutput("borrow_result", out_result, 8'hFA);
    checkOutput("borrow_flags", flags_q, 8'h16);
    tick();

    // Reset mid-stream with a full FIFO
    out_ready = 1'b0;
    applyStimulus(1'b1, 8'h01, 8'h02, 3'd0, 3'd1, 1'b1);
    tick();
    applyStimulus(1'b1, 8'h03, 8'h04, 3'd0, 3'd2, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("full_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_in_ready", in_ready, 0);
    tick();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_flags", flags_q, 0);
    checkOutput("rst_stall", stall_cnt, 0);
    checkOutput("rst_result", out_result, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst_release_ready", in_ready, 1);

    // Backpressure: three ops issued, only two fit
    applyStimulus(1'b1, 8'h10, 8'h01, 3'd0, 3'd1, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h20, 8'h02, 3'd0, 3'd2, 1'b0);
    checkOutput("bp_ready_one", in_ready, 1);
    tick();
    applyStimulus(1'b1, 8'h30, 8'h03, 3'd0, 3'd4, 1'b0);
    checkOutput("bp_ready_full", in_ready, 0);
    tick();
    tick();
    checkOutput("bp_hold_result", out_result, 8'h11);
    checkOutput("bp_hold_rd", out_rd, 1);
    checkOutput("bp_stall", stall_cnt, 3);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_no_comb_path", in_ready, 0);
    tick();
    checkOutput("bp_second_result", out_result, 8'h22);
    checkOutput("bp_second_rd", out_rd, 2);
    checkOutput("bp_ready_after_pop", in_ready, 1);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
    checkOutput("bp_third_valid", out_valid, 1);
    checkOutput("bp_third_result", out_result, 8'h33);
    checkOutput("bp_third_rd", out_rd, 4);
    tick();
    checkOutput("bp_drained", out_valid, 0);
    checkOutput("bp_stall_final", stall_cnt, 3);

    // Streaming: one result per cycle, occupancy never reaches two
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'(i), 8'h01, 3'd0, 3'(i), 1'b0);
      tick();
      checkOutput("stream_result", out_result, 32'((i + 1) & 8'hFF));
      checkOutput("stream_rd", out_rd, 32'(i % 8));
      checkOutput("stream_ready", in_ready, 1);
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
    tick();
    checkOutput("stream_drained", out_valid, 0);

    // Saturation of the 4-bit counter in the second instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b1, 8'h01, 8'h01, 3'd0, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) checkOutput("sat_below", sat_stall_cnt, 4'hE);
      if (k == 15) checkOutput("sat_reach", sat_stall_cnt, 4'hF);
    end
    checkOutput("sat_hold", sat_stall_cnt, 4'hF);
    checkOutput("wide_stall", stall_cnt, 20);
    checkOutput("sat_hold_result", sat_out_result, 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end
endmodule
